pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg_pkg.sv | 20 ++
 rtl/pipe_stage_reg_slot.sv | 25 ++
 rtl/pipe_stage_reg.sv | 116 +++++++++++
 tb/tb_pipe_stage_reg.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-stage types: handshake state encoding and the occupancy width.
package common;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_t;

    localparam int PIPE_OCC_W = 2;

    function automatic logic [PIPE_OCC_W-1:0] pipe_occ(input pipe_state_t s);
        case (s)
            PS_ONE:  return PIPE_OCC_W'(1);
            PS_FULL: return PIPE_OCC_W'(2);
            default: return PIPE_OCC_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One payload slot of the elastic stage: load enable plus a synchronous clear to the bubble value.
module pipe_slot_reg #(
    parameter int               WIDTH       = 64,
    parameter logic [WIDTH-1:0] BUBBLE_DATA = '0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (clear) begin
            data_reg <= BUBBLE_DATA;
        end else if (load) begin
            data_reg <= d;
        end
    end

    assign q = data_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with flush and bubble value.
// Define PIPE_STAGE_SKID_EN to build the skid slot and get a registered in_ready.
module pipe_stage_reg
    import common::*;
#(
    parameter int               WIDTH       = 64,
    parameter logic [WIDTH-1:0] BUBBLE_DATA = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_bubble,
    output logic [PIPE_OCC_W-1:0] occupancy
);

    pipe_state_t      state_reg;
    pipe_state_t      state_next;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] m_din;
    logic             m_load;
    logic             s_load;
    logic             in_fire;
    logic             out_fire;
    logic             clear;

    assign clear     = reset || flush;
    assign out_valid = (state_reg != PS_EMPTY);
    assign out_data  = out_valid ? m_data : BUBBLE_DATA;
    assign out_bubble = !out_valid;
    assign occupancy = pipe_occ(state_reg);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic [WIDTH-1:0] s_data;

    assign in_ready = !reset && (state_reg != PS_FULL);

    pipe_slot_reg #(
        .WIDTH      (WIDTH),
        .BUBBLE_DATA(BUBBLE_DATA)
    ) u_slot_s (
        .clk  (clk),
        .clear(clear),
        .load (s_load),
        .d    (in_data),
        .q    (s_data)
    );
`else
    // Without the skid slot, ready has to look through to the downstream consumer.
    assign in_ready = !reset && (!out_valid || out_ready);
`endif

    always_comb begin
        state_next = state_reg;
        m_load     = 1'b0;
        s_load     = 1'b0;
        m_din      = in_data;
        case (state_reg)
            PS_EMPTY: begin
                if (in_fire) begin
                    state_next = PS_ONE;
                    m_load     = 1'b1;
                end
            end
            PS_ONE: begin
                if (in_fire && out_fire) begin
                    m_load = 1'b1;
                end else if (out_fire) begin
                    state_next = PS_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                end else if (in_fire) begin
                    state_next = PS_FULL;
                    s_load     = 1'b1;
`endif
                end
            end
`ifdef PIPE_STAGE_SKID_EN
            PS_FULL: begin
                if (out_fire) begin
                    state_next = PS_ONE;
                    m_load     = 1'b1;
                    m_din      = s_data;
                end
            end
`endif
            default: state_next = PS_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg <= PS_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    pipe_slot_reg #(
        .WIDTH      (WIDTH),
        .BUBBLE_DATA(BUBBLE_DATA)
    ) u_slot_m (
        .clk  (clk),
        .clear(clear),
        .load (m_load),
        .d    (m_din),
        .q    (m_data)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed vector table plus randomized stress of pipe_stage_reg against a queue model.
module tb_pipe_stage_reg;

    localparam int               W      = 16;
    localparam logic [W-1:0]     BUBBLE = 16'hDEAD;
`ifdef PIPE_STAGE_SKID_EN
    localparam int               CAP    = 2;
`else
    localparam int               CAP    = 1;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_bubble;
    logic [1:0]   occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .WIDTH      (W),
        .BUBBLE_DATA(BUBBLE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_bubble(out_bubble),
        .occupancy (occupancy)
    );

    typedef struct {
        logic         rst;
        logic         fl;
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         e_ir;
        logic         e_ov;
        logic [W-1:0] e_data;
        logic [1:0]   e_occ;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                                input logic [W-1:0] d, input logic ordy, input logic e_ir,
                                input logic e_ov, input logic [W-1:0] e_data,
                                input logic [1:0] e_occ);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_data = e_data; v.e_occ = e_occ;
        return v;
    endfunction

    // Reference model: a FIFO of at most CAP payloads.
    logic [W-1:0] q[$];

    task automatic check_model(input string tag);
        logic         m_ir;
        logic [W-1:0] m_data;
        m_ir   = !reset && ((CAP == 2) ? (q.size() < 2) : (q.size() == 0 || out_ready));
        m_data = (q.size() > 0) ? q[0] : BUBBLE;
        chk({tag, ".in_ready"},   32'(in_ready),   32'(m_ir));
        chk({tag, ".out_valid"},  32'(out_valid),  32'(q.size() > 0));
        chk({tag, ".out_bubble"}, 32'(out_bubble), 32'(q.size() == 0));
        chk({tag, ".out_data"},   32'(out_data),   32'(m_data));
        chk({tag, ".occupancy"},  32'(occupancy),  32'(q.size()));
    endtask

    task automatic model_edge();
        logic m_ir, ifire, ofire;
        m_ir  = !reset && ((CAP == 2) ? (q.size() < 2) : (q.size() == 0 || out_ready));
        ifire = in_valid && m_ir;
        ofire = (q.size() > 0) && out_ready;
        if (reset || flush) begin
            q.delete();
        end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) q.push_back(in_data);
        end
    endtask

    initial begin
        int delivered;
        int dropped_cycles;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        //           rst fl iv data    ordy  ir ov data    occ
        vecs[0]  = mk(1, 0, 0, 16'h0,  1,    0, 0, BUBBLE, 0);
        vecs[1]  = mk(0, 0, 1, 16'h1,  1,    1, 0, BUBBLE, 0);
        vecs[2]  = mk(0, 0, 1, 16'h2,  1,    1, 1, 16'h1,  1);
        vecs[3]  = mk(0, 0, 1, 16'h3,  1,    1, 1, 16'h2,  1);
        vecs[4]  = mk(0, 0, 0, 16'h0,  1,    1, 1, 16'h3,  1);
        vecs[5]  = mk(0, 0, 0, 16'h0,  1,    1, 0, BUBBLE, 0);
        vecs[6]  = mk(0, 0, 1, 16'hA,  0,    1, 0, BUBBLE, 0);
`ifdef PIPE_STAGE_SKID_EN
        vecs[7]  = mk(0, 0, 1, 16'hB,  0,    1, 1, 16'hA,  1);
        vecs[8]  = mk(0, 0, 1, 16'hC,  0,    0, 1, 16'hA,  2);
        vecs[9]  = mk(0, 0, 0, 16'h0,  1,    0, 1, 16'hA,  2);
        vecs[10] = mk(0, 0, 0, 16'h0,  1,    1, 1, 16'hB,  1);
        vecs[11] = mk(0, 0, 0, 16'h0,  1,    1, 0, BUBBLE, 0);
        vecs[12] = mk(0, 0, 1, 16'hA,  0,    1, 0, BUBBLE, 0);
        vecs[13] = mk(0, 0, 1, 16'hB,  0,    1, 1, 16'hA,  1);
        vecs[14] = mk(0, 1, 1, 16'hC,  1,    0, 1, 16'hA,  2);
`else
        vecs[7]  = mk(0, 0, 1, 16'hB,  0,    0, 1, 16'hA,  1);
        vecs[8]  = mk(0, 0, 1, 16'hB,  1,    1, 1, 16'hA,  1);
        vecs[9]  = mk(0, 0, 0, 16'h0,  0,    0, 1, 16'hB,  1);
        vecs[10] = mk(0, 0, 0, 16'h0,  1,    1, 1, 16'hB,  1);
        vecs[11] = mk(0, 0, 0, 16'h0,  1,    1, 0, BUBBLE, 0);
        vecs[12] = mk(0, 0, 1, 16'hA,  0,    1, 0, BUBBLE, 0);
        vecs[13] = mk(0, 0, 1, 16'hB,  0,    0, 1, 16'hA,  1);
        vecs[14] = mk(0, 1, 1, 16'hC,  1,    1, 1, 16'hA,  1);
`endif
        vecs[15] = mk(0, 0, 0, 16'h0,  1,    1, 0, BUBBLE, 0);
        vecs[16] = mk(0, 0, 1, 16'h5,  0,    1, 0, BUBBLE, 0);
        vecs[17] = mk(1, 0, 1, 16'h6,  0,    0, 1, 16'h5,  1);
        vecs[18] = mk(0, 0, 0, 16'h0,  0,    1, 0, BUBBLE, 0);
        vecs[19] = mk(0, 0, 1, 16'h7,  0,    1, 0, BUBBLE, 0);
`ifdef PIPE_STAGE_SKID_EN
        vecs[20] = mk(0, 1, 1, 16'h8,  0,    1, 1, 16'h7,  1);
`else
        vecs[20] = mk(0, 1, 1, 16'h8,  0,    0, 1, 16'h7,  1);
`endif
        vecs[21] = mk(0, 0, 0, 16'h0,  0,    1, 0, BUBBLE, 0);

        for (int i = 0; i < 22; i++) begin
            reset = vecs[i].rst; flush = vecs[i].fl; in_valid = vecs[i].iv;
            in_data = vecs[i].d; out_ready = vecs[i].ordy;
            #4;
            chk($sformatf("vec%0d.in_ready", i),   32'(in_ready),   32'(vecs[i].e_ir));
            chk($sformatf("vec%0d.out_valid", i),  32'(out_valid),  32'(vecs[i].e_ov));
            chk($sformatf("vec%0d.out_bubble", i), 32'(out_bubble), 32'(!vecs[i].e_ov));
            chk($sformatf("vec%0d.out_data", i),   32'(out_data),   32'(vecs[i].e_data));
            chk($sformatf("vec%0d.occupancy", i),  32'(occupancy),  32'(vecs[i].e_occ));
            $display("vec %0d: rst=%0b fl=%0b iv=%0b d=%0h ordy=%0b -> ir=%0b ov=%0b data=%0h occ=%0d",
                     i, reset, flush, in_valid, in_data, out_ready,
                     in_ready, out_valid, out_data, occupancy);
            @(posedge clk);
            #1;
        end

        // Randomized stress against the queue model.
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        delivered = 0;
        dropped_cycles = 0;
        for (int c = 0; c < 10000; c++) begin
            reset     = ($urandom_range(0, 499) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = W'($urandom);
            #4;
            check_model("rand");
            if (out_valid && out_ready) delivered++;
            if (reset || flush) dropped_cycles++;
            model_edge();
            @(posedge clk);
            #1;
        end
        $display("random phase: %0d deliveries, %0d flush/reset cycles", delivered, dropped_cycles);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
